// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
//   Decode-to-execute bus carried into the ID/EX pipeline register.
//   master : the decode stage (drives every field)
//   slave  : id_ex_stage (samples every field)
//   Signals:
//     ID_Valid      decode presents a valid instruction
//     ID_Rs_Data    register-file read data, source 0
//     ID_Rt_Data    register-file read data, source 1
//     ID_Imm        sign-extended immediate
//     ID_Use_Imm    1: ALU operand 1 comes from the immediate
//     ID_Rs_Addr    source 0 register index
//     ID_Rt_Addr    source 1 register index
//     ID_Rd_Addr    destination register index
//     ID_ALU_Sel    ALU operation code
//     ID_Reg_Write  instruction writes Rd
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 3
);
  logic              ID_Valid;
  logic [DATA_W-1:0] ID_Rs_Data;
  logic [DATA_W-1:0] ID_Rt_Data;
  logic [DATA_W-1:0] ID_Imm;
  logic              ID_Use_Imm;
  logic [ADDR_W-1:0] ID_Rs_Addr;
  logic [ADDR_W-1:0] ID_Rt_Addr;
  logic [ADDR_W-1:0] ID_Rd_Addr;
  logic [SEL_W-1:0]  ID_ALU_Sel;
  logic              ID_Reg_Write;

  modport master (
    output ID_Valid, ID_Rs_Data, ID_Rt_Data, ID_Imm, ID_Use_Imm,
           ID_Rs_Addr, ID_Rt_Addr, ID_Rd_Addr, ID_ALU_Sel, ID_Reg_Write
  );

  modport slave (
    input  ID_Valid, ID_Rs_Data, ID_Rt_Data, ID_Imm, ID_Use_Imm,
           ID_Rs_Addr, ID_Rt_Addr, ID_Rd_Addr, ID_ALU_Sel, ID_Reg_Write
  );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with operand forwarding that drives the ALU.
//   Captures the decoded instruction, resolves RAW hazards against the
//   EX/MEM and MEM/WB stages, and supports stall and flush.
//
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     id                  decode bus (id_ex_stage_if.slave)
//     Stall, Flush        hold / kill the instruction held in EX
//     EXM_*               EX/MEM producer: write enable, destination, result
//     MWB_*               MEM/WB producer: write enable, destination, data
//     ALU_In_0, ALU_In_1  forwarded operands (operand 1 may be the immediate)
//     ALU_Sel             registered ALU operation
//     EX_Valid            EX holds a live instruction
//     EX_Rd_Addr          registered destination
//     EX_Reg_Write        registered write enable, gated by EX_Valid
//     Fwd_Sel_0/1         debug: 00 none, 01 MEM/WB, 10 EX/MEM
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  id_ex_stage_if.slave      id,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              EXM_Reg_Write,
  input  logic [ADDR_W-1:0] EXM_Rd_Addr,
  input  logic [DATA_W-1:0] EXM_Result,
  input  logic              MWB_Reg_Write,
  input  logic [ADDR_W-1:0] MWB_Rd_Addr,
  input  logic [DATA_W-1:0] MWB_Result,
  output logic [DATA_W-1:0] ALU_In_0,
  output logic [DATA_W-1:0] ALU_In_1,
  output logic [SEL_W-1:0]  ALU_Sel,
  output logic              EX_Valid,
  output logic [ADDR_W-1:0] EX_Rd_Addr,
  output logic              EX_Reg_Write,
  output logic [1:0]        Fwd_Sel_0,
  output logic [1:0]        Fwd_Sel_1
);

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MWB  = 2'b01;
  localparam logic [1:0] FWD_EXM  = 2'b10;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              use_imm;
    logic [SEL_W-1:0]  alu_sel;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
  } ex_reg_t;

  ex_reg_t ex_q;
  ex_reg_t ex_d;

  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic [1:0]        fwd_sel_0;
  logic [1:0]        fwd_sel_1;

  // A producer matches when it writes back a non-zero register equal to src.
  // r0 is hardwired to zero, so it is never a forwarding target.
  function automatic logic producer_hit(input logic              we,
                                        input logic [ADDR_W-1:0] rd,
                                        input logic [ADDR_W-1:0] src);
    return we && (rd != '0) && (rd == src);
  endfunction

  // Forwarding mux: EX/MEM is younger, so it wins over MEM/WB. A bubble in EX
  // never forwards, and operand 1 ignores forwarding when the immediate is used.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rs_fwd    = ex_q.rs_data;
    fwd_sel_0 = FWD_NONE;
    rt_fwd    = ex_q.rt_data;
    fwd_sel_1 = FWD_NONE;

    if (ex_q.valid) begin
      if (producer_hit(EXM_Reg_Write, EXM_Rd_Addr, ex_q.rs_addr)) begin
        rs_fwd    = EXM_Result;
        fwd_sel_0 = FWD_EXM;
      end else if (producer_hit(MWB_Reg_Write, MWB_Rd_Addr, ex_q.rs_addr)) begin
        rs_fwd    = MWB_Result;
        fwd_sel_0 = FWD_MWB;
      end

      if (!ex_q.use_imm) begin
        if (producer_hit(EXM_Reg_Write, EXM_Rd_Addr, ex_q.rt_addr)) begin
          rt_fwd    = EXM_Result;
          fwd_sel_1 = FWD_EXM;
        end else if (producer_hit(MWB_Reg_Write, MWB_Rd_Addr, ex_q.rt_addr)) begin
          rt_fwd    = MWB_Result;
          fwd_sel_1 = FWD_MWB;
        end
      end
    end
  end

  // Next-state: Flush > Stall > load (reset is applied in the flop).
  always_comb begin
    ex_d = ex_q;

    if (Flush) begin
      // Bubble: the remaining fields are don't-care once valid/write are low.
      ex_d.valid     = 1'b0;
      ex_d.reg_write = 1'b0;
    end else if (Stall) begin
      // A producer may retire while we are stalled; capture whatever is being
      // forwarded now so the operand survives the stall. Addresses are kept.
      if (fwd_sel_0 != FWD_NONE) ex_d.rs_data = rs_fwd;
      if (fwd_sel_1 != FWD_NONE) ex_d.rt_data = rt_fwd;
    end else begin
      ex_d.valid     = id.ID_Valid;
      ex_d.reg_write = id.ID_Reg_Write & id.ID_Valid;
      ex_d.use_imm   = id.ID_Use_Imm;
      ex_d.alu_sel   = id.ID_ALU_Sel;
      ex_d.rs_addr   = id.ID_Rs_Addr;
      ex_d.rt_addr   = id.ID_Rt_Addr;
      ex_d.rd_addr   = id.ID_Rd_Addr;
      ex_d.rs_data   = id.ID_Rs_Data;
      ex_d.rt_data   = id.ID_Rt_Data;
      ex_d.imm       = id.ID_Imm;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign ALU_In_0     = rs_fwd;
  assign ALU_In_1     = ex_q.use_imm ? ex_q.imm : rt_fwd;
  assign ALU_Sel      = ex_q.alu_sel;
  assign EX_Valid     = ex_q.valid;
  assign EX_Rd_Addr   = ex_q.rd_addr;
  assign EX_Reg_Write = ex_q.reg_write & ex_q.valid;
  assign Fwd_Sel_0    = fwd_sel_0;
  assign Fwd_Sel_1    = fwd_sel_1;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//   Scoreboard bench for id_ex_stage: directed scenarios followed by random
//   traffic. The stimulus process updates a reference model at each edge and
//   pushes the expected ALU-side view; a monitor pops and compares on the
//   falling edge.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int SEL_W  = 3;

  typedef struct packed {
    logic        rst, stall, flush;
    logic        valid, use_imm, we;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
    logic [2:0]  sel;
    logic        exm_we;
    logic [4:0]  exm_rd;
    logic [31:0] exm_res;
    logic        mwb_we;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_res;
  } stim_t;

  // The instruction the model believes is sitting in EX.
  typedef struct packed {
    logic        valid, we, use_imm;
    logic [2:0]  sel;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
  } instr_t;

  typedef struct packed {
    logic [31:0] alu0, alu1;
    logic [2:0]  sel;
    logic        valid;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  f0, f1;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic Stall, Flush;
  logic EXM_Reg_Write, MWB_Reg_Write;
  logic [ADDR_W-1:0] EXM_Rd_Addr, MWB_Rd_Addr;
  logic [DATA_W-1:0] EXM_Result, MWB_Result;
  logic [DATA_W-1:0] ALU_In_0, ALU_In_1;
  logic [SEL_W-1:0]  ALU_Sel;
  logic              EX_Valid;
  logic [ADDR_W-1:0] EX_Rd_Addr;
  logic              EX_Reg_Write;
  logic [1:0]        Fwd_Sel_0, Fwd_Sel_1;

  id_ex_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id           (bus.slave),
    .Stall        (Stall),
    .Flush        (Flush),
    .EXM_Reg_Write(EXM_Reg_Write),
    .EXM_Rd_Addr  (EXM_Rd_Addr),
    .EXM_Result   (EXM_Result),
    .MWB_Reg_Write(MWB_Reg_Write),
    .MWB_Rd_Addr  (MWB_Rd_Addr),
    .MWB_Result   (MWB_Result),
    .ALU_In_0     (ALU_In_0),
    .ALU_In_1     (ALU_In_1),
    .ALU_Sel      (ALU_Sel),
    .EX_Valid     (EX_Valid),
    .EX_Rd_Addr   (EX_Rd_Addr),
    .EX_Reg_Write (EX_Reg_Write),
    .Fwd_Sel_0    (Fwd_Sel_0),
    .Fwd_Sel_1    (Fwd_Sel_1)
  );

  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  exp_t   sb[$];
  instr_t m;
  stim_t  cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural forwarding rule: scan the producers youngest first; the
  // first one writing a non-zero register equal to addr supplies the value.
  function automatic void resolve(input instr_t i, input stim_t s, input logic [4:0] addr,
                                  input logic [31:0] own,
                                  output logic [31:0] val, output logic [1:0] code);
    logic        pw[2];
    logic [4:0]  pr[2];
    logic [31:0] pv[2];
    logic [1:0]  pc[2];
    pw[0] = s.exm_we; pr[0] = s.exm_rd; pv[0] = s.exm_res; pc[0] = 2'b10;
    pw[1] = s.mwb_we; pr[1] = s.mwb_rd; pv[1] = s.mwb_res; pc[1] = 2'b01;
    val  = own;
    code = 2'b00;
    if (i.valid) begin
      for (int k = 0; k < 2; k++) begin
        if (code == 2'b00 && pw[k] && pr[k] != 5'd0 && pr[k] == addr) begin
          val  = pv[k];
          code = pc[k];
        end
      end
    end
  endfunction

  function automatic exp_t expect_out(input instr_t i, input stim_t s);
    exp_t e;
    resolve(i, s, i.rs, i.rs_data, e.alu0, e.f0);
    if (i.use_imm) begin
      e.alu1 = i.imm;
      e.f1   = 2'b00;
    end else begin
      resolve(i, s, i.rt, i.rt_data, e.alu1, e.f1);
    end
    e.sel   = i.sel;
    e.valid = i.valid;
    e.rd    = i.rd;
    e.we    = i.we && i.valid;
    return e;
  endfunction

  // What the EX slot holds after an edge taken with inputs s.
  function automatic instr_t model_edge(input instr_t i, input stim_t s);
    instr_t n;
    logic [31:0] v;
    logic [1:0]  c;
    n = i;
    if (s.rst) begin
      n = '0;
    end else if (s.flush) begin
      n.valid = 1'b0;
      n.we    = 1'b0;
    end else if (s.stall) begin
      resolve(i, s, i.rs, i.rs_data, v, c);
      if (c != 2'b00) n.rs_data = v;
      if (!i.use_imm) begin
        resolve(i, s, i.rt, i.rt_data, v, c);
        if (c != 2'b00) n.rt_data = v;
      end
    end else begin
      n.valid   = s.valid;
      n.we      = s.we && s.valid;
      n.use_imm = s.use_imm;
      n.sel     = s.sel;
      n.rs      = s.rs;
      n.rt      = s.rt;
      n.rd      = s.rd;
      n.rs_data = s.rs_data;
      n.rt_data = s.rt_data;
      n.imm     = s.imm;
    end
    return n;
  endfunction

  task automatic apply(input stim_t s);
    rst               = s.rst;
    Stall             = s.stall;
    Flush             = s.flush;
    bus.ID_Valid      = s.valid;
    bus.ID_Use_Imm    = s.use_imm;
    bus.ID_Reg_Write  = s.we;
    bus.ID_Rs_Addr    = s.rs;
    bus.ID_Rt_Addr    = s.rt;
    bus.ID_Rd_Addr    = s.rd;
    bus.ID_Rs_Data    = s.rs_data;
    bus.ID_Rt_Data    = s.rt_data;
    bus.ID_Imm        = s.imm;
    bus.ID_ALU_Sel    = s.sel;
    EXM_Reg_Write     = s.exm_we;
    EXM_Rd_Addr       = s.exm_rd;
    EXM_Result        = s.exm_res;
    MWB_Reg_Write     = s.mwb_we;
    MWB_Rd_Addr       = s.mwb_rd;
    MWB_Result        = s.mwb_res;
  endtask

  // One cycle: the edge consumes cur, then s is driven for the next cycle.
  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    m   = model_edge(m, cur);
    cur = s;
    apply(s);
    #1;
    sb.push_back(expect_out(m, s));
  endtask

  // Monitor: the EX stage presents a result every cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("sb_alu_in_0",     ALU_In_0,               e.alu0);
      check("sb_alu_in_1",     ALU_In_1,               e.alu1);
      check("sb_alu_sel",      {29'd0, ALU_Sel},       {29'd0, e.sel});
      check("sb_ex_valid",     {31'd0, EX_Valid},      {31'd0, e.valid});
      check("sb_ex_rd_addr",   {27'd0, EX_Rd_Addr},    {27'd0, e.rd});
      check("sb_ex_reg_write", {31'd0, EX_Reg_Write},  {31'd0, e.we});
      check("sb_fwd_sel_0",    {30'd0, Fwd_Sel_0},     {30'd0, e.f0});
      check("sb_fwd_sel_1",    {30'd0, Fwd_Sel_1},     {30'd0, e.f1});
    end
  end

  initial begin
    stim_t s;
    m   = '0;
    cur = '0;
    cur.rst = 1'b1;
    apply(cur);

    // Reset held for two cycles: everything reads zero.
    s = '0; s.rst = 1'b1;
    step(s);
    step(s);
    check("rst_alu_in_0", ALU_In_0, 32'd0);
    check("rst_alu_in_1", ALU_In_1, 32'd0);
    check("rst_ex_valid", {31'd0, EX_Valid}, 32'd0);
    check("rst_alu_sel",  {29'd0, ALU_Sel}, 32'd0);

    // Load, visible one cycle after the capturing edge.
    s = '0; s.valid = 1; s.rs_data = 32'd5; s.rt_data = 32'd3; s.sel = 3'b001;
    s.rd = 5'd4; s.rs = 5'd1; s.rt = 5'd2; s.we = 1;
    step(s);
    s = '0;
    step(s);
    check("load_alu_in_0", ALU_In_0, 32'd5);
    check("load_alu_in_1", ALU_In_1, 32'd3);
    check("load_alu_sel",  {29'd0, ALU_Sel}, 32'd1);
    check("load_ex_valid", {31'd0, EX_Valid}, 32'd1);
    check("load_rd",       {27'd0, EX_Rd_Addr}, 32'd4);

    // Forward priority: EX/MEM over MEM/WB, then MEM/WB alone.
    s = '0; s.valid = 1; s.we = 1; s.rs = 5'd7; s.rt = 5'd7; s.rs_data = 32'd1; s.rt_data = 32'd2;
    step(s);
    s = '0; s.stall = 1; s.exm_we = 1; s.exm_rd = 5'd7; s.exm_res = 32'hAA;
    s.mwb_we = 1; s.mwb_rd = 5'd7; s.mwb_res = 32'hBB;
    step(s);
    check("prio_alu_in_0", ALU_In_0, 32'hAA);
    check("prio_alu_in_1", ALU_In_1, 32'hAA);
    check("prio_fwd_0", {30'd0, Fwd_Sel_0}, 32'd2);
    check("prio_fwd_1", {30'd0, Fwd_Sel_1}, 32'd2);
    s.exm_we = 0;
    step(s);
    check("mwb_alu_in_0", ALU_In_0, 32'hBB);
    check("mwb_alu_in_1", ALU_In_1, 32'hBB);
    check("mwb_fwd_0", {30'd0, Fwd_Sel_0}, 32'd1);

    // r0 is never forwarded.
    s = '0; s.valid = 1; s.rs = 5'd0; s.rs_data = 32'h11; s.rt = 5'd5;
    step(s);
    s = '0; s.stall = 1; s.exm_we = 1; s.exm_rd = 5'd0; s.exm_res = 32'hFF;
    step(s);
    check("r0_alu_in_0", ALU_In_0, 32'h11);
    check("r0_fwd_0", {30'd0, Fwd_Sel_0}, 32'd0);

    // Immediate shadows Rt forwarding.
    s = '0; s.valid = 1; s.use_imm = 1; s.imm = 32'hFFFF_FFF0; s.rt = 5'd9; s.rt_data = 32'h77;
    step(s);
    s = '0; s.stall = 1; s.mwb_we = 1; s.mwb_rd = 5'd9; s.mwb_res = 32'h99;
    step(s);
    check("imm_alu_in_1", ALU_In_1, 32'hFFFF_FFF0);
    check("imm_fwd_1", {30'd0, Fwd_Sel_1}, 32'd0);

    // Forwarded operand survives a three-cycle stall after the producer retires.
    s = '0; s.valid = 1; s.we = 1; s.rs = 5'd3; s.rs_data = 32'h55;
    step(s);
    s = '0; s.stall = 1; s.exm_we = 1; s.exm_rd = 5'd3; s.exm_res = 32'h1234;
    step(s);
    check("stall_c1", ALU_In_0, 32'h1234);
    s.exm_we = 0; s.mwb_we = 0;
    step(s);
    check("stall_c2", ALU_In_0, 32'h1234);
    step(s);
    check("stall_c3", ALU_In_0, 32'h1234);
    s = '0;
    step(s);
    check("stall_release", ALU_In_0, 32'h1234);

    // Flush wins over Stall on the same edge.
    s = '0; s.valid = 1; s.we = 1; s.rd = 5'd6; s.rs = 5'd2; s.rt = 5'd2;
    step(s);
    s = '0; s.stall = 1; s.flush = 1; s.exm_we = 1; s.exm_rd = 5'd2; s.exm_res = 32'hCC;
    step(s);
    s.stall = 0; s.flush = 0;
    step(s);
    check("flush_ex_valid", {31'd0, EX_Valid}, 32'd0);
    check("flush_reg_write", {31'd0, EX_Reg_Write}, 32'd0);
    check("flush_fwd_0", {30'd0, Fwd_Sel_0}, 32'd0);
    check("flush_fwd_1", {30'd0, Fwd_Sel_1}, 32'd0);

    // Random traffic with a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      s = '0;
      s.rst     = ($urandom_range(0, 49) == 0);
      s.stall   = ($urandom_range(0, 4) == 0);
      s.flush   = ($urandom_range(0, 9) == 0);
      s.valid   = ($urandom_range(0, 3) != 0);
      s.use_imm = ($urandom_range(0, 3) == 0);
      s.we      = 1'($urandom_range(0, 1));
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.rd      = 5'($urandom_range(0, 31));
      s.rs_data = $urandom;
      s.rt_data = $urandom;
      s.imm     = $urandom;
      s.sel     = 3'($urandom_range(0, 7));
      s.exm_we  = 1'($urandom_range(0, 1));
      s.exm_rd  = 5'($urandom_range(0, 3));
      s.exm_res = $urandom;
      s.mwb_we  = 1'($urandom_range(0, 1));
      s.mwb_rd  = 5'($urandom_range(0, 3));
      s.mwb_res = $urandom;
      step(s);
    end

    repeat (2) @(negedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus operand-forwarding stage that feeds the ALU directly.
- Captures decoded operands, immediate, ALU select and destination info from decode.
- Resolves RAW hazards against the EX/MEM and MEM/WB stages, supports stall and flush, and presents ALU_In_0, ALU_In_1 and ALU_Sel to the ALU.

Parameters:
- DATA_W, 32, operand/result width (matches ALU).
- ADDR_W, 5, register address width.
- SEL_W, 3, ALU select width.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ID_Valid  in  1  decode presents a valid instruction.
- ID_Rs_Data  in  DATA_W  register-file read data, source 0.
- ID_Rt_Data  in  DATA_W  register-file read data, source 1.
- ID_Imm  in  DATA_W  sign-extended immediate.
- ID_Use_Imm  in  1  1: ALU_In_1 comes from the immediate.
- ID_Rs_Addr  in  ADDR_W  source 0 register index.
- ID_Rt_Addr  in  ADDR_W  source 1 register index.
- ID_Rd_Addr  in  ADDR_W  destination register index.
- ID_ALU_Sel  in  SEL_W  ALU operation (000 add, 001 sub, 010 and, 011 or, 100 xor).
- ID_Reg_Write  in  1  instruction writes Rd.
- Stall  in  1  hold current EX contents.
- Flush  in  1  kill current EX contents.
- EXM_Reg_Write  in  1  EX/MEM instruction writes back.
- EXM_Rd_Addr  in  ADDR_W  EX/MEM destination.
- EXM_Result  in  DATA_W  EX/MEM registered ALU result.
- MWB_Reg_Write  in  1  MEM/WB instruction writes back.
- MWB_Rd_Addr  in  ADDR_W  MEM/WB destination.
- MWB_Result  in  DATA_W  MEM/WB writeback data.
- ALU_In_0  out  DATA_W  forwarded operand 0 to the ALU.
- ALU_In_1  out  DATA_W  forwarded operand 1 or the immediate.
- ALU_Sel  out  SEL_W  registered ALU select.
- EX_Valid  out  1  EX stage holds a live instruction.
- EX_Rd_Addr  out  ADDR_W  registered destination.
- EX_Reg_Write  out  1  registered write enable, gated by EX_Valid.
- Fwd_Sel_0  out  2  debug: 00 none, 01 MEM/WB, 10 EX/MEM.
- Fwd_Sel_1  out  2  debug: same encoding for source 1.

Behaviour:
- Reset (rst=1 at an edge):
  - All registers clear to 0. EX_Valid=0, EX_Reg_Write=0, ALU_Sel=000, EX_Rd_Addr=0.
  - ALU_In_0 and ALU_In_1 read 0, because the registered operands and addresses are 0 and no forwarding matches r0.
  - Reset overrides Stall and Flush.
- Edge priority, evaluated each edge: rst > Flush > Stall > load.
- Load (no rst/Flush/Stall):
  - Register all ID_* fields.
  - EX_Valid <= ID_Valid.
  - Stored Reg_Write <= ID_Reg_Write & ID_Valid.
- Flush:
  - EX_Valid <= 0 and stored Reg_Write <= 0, inserting a bubble.
  - Other fields may keep any value but must not forward or write.
  - Flush while Stall is high still bubbles.
- Stall:
  - Hold all fields.
  - Exception: each operand register is overwritten with its current forwarded value (ALU_In_0 source, Rs data) whenever Fwd_Sel_x != 00.
  - This preserves forwarded data after the producer retires during a multi-cycle stall. The stored address is unchanged.
- Forwarding (combinational from registered Rs/Rt address and data):
  - EX/MEM match: EXM_Reg_Write=1, EXM_Rd_Addr!=0, EXM_Rd_Addr==Rs. Selects EXM_Result, Fwd_Sel=10.
  - Else MEM/WB match under the same rules: selects MWB_Result, Fwd_Sel=01.
  - Else the registered data, Fwd_Sel=00.
  - EX/MEM takes priority over MEM/WB when both match.
  - Register 0 is never forwarded.
  - The same rules apply independently for Rt.
  - When EX_Valid=0, Fwd_Sel_0 and Fwd_Sel_1 = 00.
- ALU_In_1 = stored Use_Imm ? stored Imm : forwarded Rt. Forwarding on Rt is ignored when Use_Imm=1, and Fwd_Sel_1 reports 00.
- Latency: ID inputs appear at ALU_In_x/ALU_Sel one cycle after the capturing edge. Forwarding is zero-latency, combinational within the cycle.
- Widths: no arithmetic in this block. Values pass through unchanged.
- Undefined ALU_Sel codes (101–111) are passed through unchanged; the ALU outputs 0 for them.

Test Plan:
- Reset and load:
  - Hold rst 2 cycles.
  - Then load ID_Rs_Data=5, ID_Rt_Data=3, Sel=001, Rd=4, Valid=1.
  - Required: all outputs 0 during reset; next cycle ALU_In_0=5, ALU_In_1=3, ALU_Sel=001, EX_Valid=1, EX_Rd_Addr=4.
- Forward priority:
  - Stored Rs=Rt=7; EXM Rd=7, Result=0xAA, Write=1; MWB Rd=7, Result=0xBB, Write=1.
  - Required: ALU_In_0=ALU_In_1=0xAA, Fwd_Sel=10 for both.
  - Then drop EXM_Reg_Write -> both 0xBB, Fwd_Sel=01.
- r0 guard:
  - Stored Rs=0, data 0x11; EXM Rd=0, Write=1, Result=0xFF.
  - Required: ALU_In_0=0x11, Fwd_Sel_0=00.
- Immediate:
  - Use_Imm=1, Imm=0xFFFFFFF0, Rt=9; MWB Rd=9, Write=1.
  - Required: ALU_In_1=0xFFFFFFF0, Fwd_Sel_1=00.
- Stall capture:
  - Stored Rs=3; EXM forwards 0x1234 to Rs.
  - Assert Stall 3 cycles; after cycle 1 set EXM_Reg_Write=0 and MWB_Reg_Write=0.
  - Required: ALU_In_0 stays 0x1234 for all 3 cycles and after release.
- Flush vs stall:
  - Assert Stall=1 and Flush=1 on the same edge with EX_Valid=1, Reg_Write=1.
  - Required: next cycle EX_Valid=0, EX_Reg_Write=0, Fwd_Sel_0=Fwd_Sel_1=00.
